// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and default geometry for the line-buffer sequencer.
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } lb_state_e;

  localparam int DEF_COL     = 640;
  localparam int DEF_ROW     = 480;
  localparam int DEF_LINES   = 2;
  localparam int DEF_CW      = 10;
  localparam int DEF_RW      = 10;
  localparam int DEF_TIMEOUT = 4096;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Pixel-stream inputs and line-FIFO/window control outputs of the sequencer.
interface line_buf_ctrl_if
  import line_buf_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int CW    = DEF_CW,
  parameter int RW    = DEF_RW
);

  logic             frame_start;
  logic             din_vld;
  logic [LINES-1:0] fifo_wrreq;
  logic [LINES-1:0] fifo_rdreq;
  logic             fifo_sclr;
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic             win_vld;
  logic             win_border;
  logic             frame_done;
  logic             err_overrun;
  logic             timeout;

  modport master (
    output frame_start, din_vld,
    input  fifo_wrreq, fifo_rdreq, fifo_sclr, col_cnt, row_cnt,
           win_vld, win_border, frame_done, err_overrun, timeout
  );

  modport slave (
    input  frame_start, din_vld,
    output fifo_wrreq, fifo_rdreq, fifo_sclr, col_cnt, row_cnt,
           win_vld, win_border, frame_done, err_overrun, timeout
  );

endinterface

// File: rtl/line_buf_ctrl_frame_watchdog.sv
// Idle-cycle watchdog for an active frame: fires a one-cycle pulse after TIMEOUT
// cycles without a pixel; counter is held at zero whenever not enabled.
module frame_watchdog
  import line_buf_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic fire
);

  localparam int            TW    = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt;

  assign fire = en && !kick && (idle_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !en || kick || fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Line-buffer sequencer: pixel/row counting, line-FIFO strobes, window-valid flags.
// Optional idle watchdog enabled by defining FRAME_TIMEOUT_EN.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int ROW     = DEF_ROW,
  parameter int LINES   = DEF_LINES,
  parameter int CW      = DEF_CW,
  parameter int RW      = DEF_RW,
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input logic            vga_clk,
  input logic            rst,
  line_buf_ctrl_if.slave lb
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic             active;
  logic             pix;
  logic             col_last;
  logic             row_last;
  logic             wd_fire;
  logic             win_vld;
  logic             win_border;
  logic             frame_done;
  logic             err_overrun;
  logic [LINES-1:0] wrreq;
  logic [LINES-1:0] rdreq;

  // A pixel is only consumed in FILL/RUN; a coincident frame_start drops it.
  assign active   = !rst && (state == ST_FILL || state == ST_RUN);
  assign pix      = active && lb.din_vld && !lb.frame_start;
  assign col_last = (col_cnt == CW'(COL - 1));
  assign row_last = (row_cnt == RW'(ROW - 1));

  // FIFO k delays by k+1 lines: written from row k, read once it holds a full line.
  always_comb begin
    wrreq = '0;
    rdreq = '0;
    for (int k = 0; k < LINES; k++) begin
      wrreq[k] = pix && (row_cnt >= RW'(k));
      rdreq[k] = pix && (row_cnt >= RW'(k + 1));
    end
  end

  always_comb begin
    state_nxt = state;
    if (lb.frame_start) begin
      state_nxt = ST_FILL;
    end else if (wd_fire) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_FILL: if (pix && col_last && row_cnt == RW'(LINES - 1)) state_nxt = ST_RUN;
        ST_RUN:  if (pix && col_last && row_last)                  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      col_cnt     <= '0;
      row_cnt     <= '0;
      win_vld     <= 1'b0;
      win_border  <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      win_vld    <= pix && (row_cnt >= RW'(LINES)) && (col_cnt >= CW'(LINES));
      win_border <= pix && ((row_cnt < RW'(LINES)) || (col_cnt < CW'(LINES)));
      frame_done <= (state_nxt == ST_DONE);
      if (lb.frame_start) begin
        col_cnt     <= '0;
        row_cnt     <= '0;
        err_overrun <= 1'b0;
      end else if (wd_fire) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (pix) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end else if (!active && lb.din_vld) begin
        err_overrun <= 1'b1;
      end
    end
  end

`ifdef FRAME_TIMEOUT_EN
  frame_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_frame_watchdog (
    .clk  (vga_clk),
    .rst  (rst),
    .en   (active && !lb.frame_start),
    .kick (lb.din_vld),
    .fire (wd_fire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_fire        = 1'b0;
`endif

  assign lb.fifo_wrreq  = wrreq;
  assign lb.fifo_rdreq  = rdreq;
  assign lb.fifo_sclr   = !rst && (lb.frame_start || wd_fire);
  assign lb.col_cnt     = col_cnt;
  assign lb.row_cnt     = row_cnt;
  assign lb.win_vld     = win_vld;
  assign lb.win_border  = win_border;
  assign lb.frame_done  = frame_done;
  assign lb.err_overrun = err_overrun;
  assign lb.timeout     = wd_fire;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl on an 8x6 frame with two line FIFOs.
module tb_line_buf_ctrl;

  localparam int COL     = 8;
  localparam int ROW     = 6;
  localparam int LINES   = 2;
  localparam int CW      = 4;
  localparam int RW      = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buf_ctrl_if #(.LINES(LINES), .CW(CW), .RW(RW)) lb();

  line_buf_ctrl #(
    .COL(COL), .ROW(ROW), .LINES(LINES), .CW(CW), .RW(RW), .TIMEOUT(TIMEOUT)
  ) dut (
    .vga_clk (clk),
    .rst     (rst),
    .lb      (lb)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int win_cnt  = 0;
  int done_cnt = 0;
  int to_cnt   = 0;
  int to_sclr  = 0;
  int to_cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lb.win_vld)    win_cnt  = win_cnt + 1;
    if (lb.frame_done) done_cnt = done_cnt + 1;
    if (lb.timeout) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
      if (lb.fifo_sclr) to_sclr = to_sclr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    lb.frame_start = 1'b1;
    #1;
    chk("sclr_on_start", 32'(lb.fifo_sclr), 1);
    tick();
    lb.frame_start = 1'b0;
  endtask

  // One pixel in the current cycle followed by gap blanking cycles.
  task automatic pixel(input int gap);
    lb.din_vld = 1'b1;
    tick();
    lb.din_vld = 1'b0;
    repeat (gap) tick();
  endtask

  // Contiguous full frame from the current state, checking window count and done pulse.
  task automatic full_frame(input string tag);
    int bw, bd;
    bw = win_cnt;
    bd = done_cnt;
    for (int i = 1; i <= COL * ROW; i++) pixel(0);
    chk({tag, "_done"}, 32'(lb.frame_done), 1);
    tick();
    chk({tag, "_done_pulse"}, 32'(lb.frame_done), 0);
    tick();
    chk({tag, "_win_cnt"}, 32'(win_cnt - bw), 24);
    chk({tag, "_done_cnt"}, 32'(done_cnt - bd), 1);
  endtask

  int bw, bd, bt, bs, last_cyc;

  initial begin
    rst            = 1'b1;
    lb.frame_start = 1'b0;
    lb.din_vld     = 1'b0;
    repeat (3) tick();
    chk("rst_col", 32'(lb.col_cnt), 0);
    chk("rst_row", 32'(lb.row_cnt), 0);
    chk("rst_outs", 32'({lb.win_vld, lb.win_border, lb.frame_done, lb.err_overrun,
                         lb.timeout, lb.fifo_sclr, lb.fifo_wrreq, lb.fifo_rdreq}), 0);
    rst = 1'b0;
    tick();

    // Test 1: contiguous frame
    start_frame();
    bw = win_cnt;
    bd = done_cnt;
    for (int i = 1; i <= 48; i++) begin
      lb.din_vld = 1'b1;
      #1;
      if (i == 1)  chk("t1_wr_p1", 32'(lb.fifo_wrreq), 1);
      if (i == 1)  chk("t1_rd_p1", 32'(lb.fifo_rdreq), 0);
      if (i == 9)  chk("t1_rd_p9", 32'(lb.fifo_rdreq), 1);
      if (i == 17) chk("t1_rd_p17", 32'(lb.fifo_rdreq), 3);
      tick();
      lb.din_vld = 1'b0;
      if (i == 1)  chk("t1_border_p1", 32'(lb.win_border), 1);
      if (i == 18) chk("t1_win_p18", 32'(lb.win_vld), 0);
      if (i == 18) chk("t1_border_p18", 32'(lb.win_border), 1);
      if (i == 19) chk("t1_win_p19", 32'(lb.win_vld), 1);
      if (i == 19) chk("t1_border_p19", 32'(lb.win_border), 0);
      if (i == 47) chk("t1_done_p47", 32'(lb.frame_done), 0);
    end
    chk("t1_done", 32'(lb.frame_done), 1);
    tick();
    chk("t1_done_pulse", 32'(lb.frame_done), 0);
    tick();
    chk("t1_win_cnt", 32'(win_cnt - bw), 24);
    chk("t1_done_cnt", 32'(done_cnt - bd), 1);

    // Test 4: stray pixel after the frame is an overrun
    lb.din_vld = 1'b1;
    #1;
    chk("t4_wr_idle", 32'({lb.fifo_wrreq, lb.fifo_rdreq}), 0);
    tick();
    lb.din_vld = 1'b0;
    chk("t4_err_set", 32'(lb.err_overrun), 1);
    repeat (3) tick();
    chk("t4_err_held", 32'(lb.err_overrun), 1);
    chk("t4_col_held", 32'(lb.col_cnt), 0);
    start_frame();
    chk("t4_err_clr", 32'(lb.err_overrun), 0);

    // Test 2: 3-cycle gaps after every pixel (frame already started)
    bw = win_cnt;
    for (int i = 1; i <= 48; i++) begin
      lb.din_vld = 1'b1;
      #1;
      if (i == 8)  chk("t2_rd0_p8", 32'(lb.fifo_rdreq[0]), 0);
      if (i == 9)  chk("t2_rd0_p9", 32'(lb.fifo_rdreq[0]), 1);
      if (i == 16) chk("t2_rd1_p16", 32'(lb.fifo_rdreq[1]), 0);
      if (i == 17) chk("t2_rd1_p17", 32'(lb.fifo_rdreq[1]), 1);
      tick();
      lb.din_vld = 1'b0;
      repeat (3) tick();
      if (i == 5) chk("t2_col_gap", 32'(lb.col_cnt), 5);
      if (i == 5) chk("t2_wr_gap", 32'(lb.fifo_wrreq), 0);
      if (i == 12) chk("t2_row_gap", 32'(lb.row_cnt), 1);
    end
    tick();
    chk("t2_win_cnt", 32'(win_cnt - bw), 24);

    // Test 3: frame_start collides with pixel 20
    start_frame();
    for (int i = 1; i <= 19; i++) pixel(0);
    chk("t3_col_pre", 32'(lb.col_cnt), 3);
    lb.din_vld     = 1'b1;
    lb.frame_start = 1'b1;
    #1;
    chk("t3_sclr", 32'(lb.fifo_sclr), 1);
    chk("t3_wr_drop", 32'(lb.fifo_wrreq), 0);
    tick();
    lb.din_vld     = 1'b0;
    lb.frame_start = 1'b0;
    chk("t3_cnt_clr", 32'({lb.row_cnt, lb.col_cnt}), 0);
    full_frame("t3");

    // Test 5: reset in the middle of RUN
    start_frame();
    for (int i = 1; i <= 29; i++) pixel(0);
    chk("t5_row_pre", 32'(lb.row_cnt), 3);
    lb.din_vld = 1'b1;
    rst        = 1'b1;
    tick();
    lb.din_vld = 1'b0;
    rst        = 1'b0;
    chk("t5_cnt", 32'({lb.row_cnt, lb.col_cnt}), 0);
    chk("t5_outs", 32'({lb.win_vld, lb.win_border, lb.frame_done, lb.err_overrun,
                        lb.timeout, lb.fifo_sclr, lb.fifo_wrreq, lb.fifo_rdreq}), 0);
    start_frame();
    full_frame("t5");

    // Test 6: stream stalls after pixel 10
    start_frame();
    for (int i = 1; i <= 10; i++) pixel(0);
    last_cyc = cyc;
    bt = to_cnt;
    bs = to_sclr;
    bd = done_cnt;
    repeat (30) tick();
`ifdef FRAME_TIMEOUT_EN
    chk("t6_to_cnt", 32'(to_cnt - bt), 1);
    chk("t6_to_delay", 32'(to_cyc - last_cyc), 15);
    chk("t6_to_sclr", 32'(to_sclr - bs), 1);
    chk("t6_no_done", 32'(done_cnt - bd), 0);
    pixel(0);
    chk("t6_idle_err", 32'(lb.err_overrun), 1);
`else
    chk("t6_to_cnt", 32'(to_cnt - bt), 0);
    chk("t6_col_hold", 32'(lb.col_cnt), 2);
    chk("t6_row_hold", 32'(lb.row_cnt), 1);
    bw = win_cnt;
    for (int i = 11; i <= 48; i++) pixel(0);
    chk("t6_done", 32'(lb.frame_done), 1);
    tick();
    chk("t6_win_cnt", 32'(win_cnt - bw), 24);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
